spi_sample_rx: RTL and testbench

SPI_SAMPLE_RX -- requirements
Module: spi_sample_rx

---
 rtl/spi_sample_rx_pkg.sv | 13 +
 rtl/spi_sample_rx_if.sv | 16 +
 rtl/spi_sample_rx_fifo.sv | 77 +++++++
 rtl/spi_sample_rx.sv | 139 +++++++++++++
 tb/tb_spi_sample_rx.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/spi_sample_rx_pkg.sv
// Shared defaults and the frame-receiver state encoding.
package spi_pkg;

    localparam int SAMPLE_W_DEF   = 11;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ERR
    } state_t;

endpackage

// File: rtl/spi_sample_rx_if.sv
// Sample stream out of the receiver: FWFT head, valid/ready handshake, occupancy.
interface spi_sample_rx_if import spi_pkg::*; #(
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [SAMPLE_W-1:0] sample;
    logic                valid;
    logic                ready;
    logic [CW-1:0]       count;

    modport master (output sample, output valid, output count, input ready);
    modport slave  (input sample, input valid, input count, output ready);

endinterface

// File: rtl/spi_sample_rx_fifo.sv
// First-word-fall-through sample buffer with occupancy and overflow pulse.
module sample_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [W-1:0]                 wr_data,
    input  logic                         ready,
    output logic [W-1:0]                 rd_data,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          full, empty, do_pop, do_push;

    // Pointers wrap at DEPTH even when DEPTH is not a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full buffer is still accepted when the head leaves in the same cycle.
    always_comb begin
        empty    = (cnt_q == '0);
        full     = (cnt_q == CW'(DEPTH));
        do_pop   = ready & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = push & full & ~do_pop;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop)
            rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign valid    = ~empty;
    assign count    = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/spi_sample_rx.sv
// SPI mode-0 slave receiver: one ncs-low period carries one SAMPLE_W-bit frame,
// MSB first; good frames land in a small FWFT buffer.
module spi_sample_rx import spi_pkg::*; #(
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sclk,
    input  logic            ncs,
    input  logic            din,
    spi_sample_rx_if.master out_if,
    output logic            frame_err,
    output logic            overflow
);
    localparam int CNTW = $clog2(SAMPLE_W + 1);

    logic [1:0] ncs_sync_q, ncs_sync_d, sclk_sync_q, sclk_sync_d, din_sync_q, din_sync_d;
    logic       ncs_s, sclk_s, din_s;
    logic       ncs_prev_q, ncs_prev_d, sclk_prev_q, sclk_prev_d;
    logic       ncs_rise_q, ncs_rise_d, ncs_fall_q, ncs_fall_d;
    logic       sclk_rise_q, sclk_rise_d, din_q, din_d;
    logic [1:0] settle_q, settle_d;
    logic       armed_q, armed_d;

    state_t              state_q;
    logic [CNTW-1:0]     bit_cnt_q;
    logic [SAMPLE_W-1:0] shift_q;
    logic                push_q, frame_err_q;

    assign ncs_s  = ncs_sync_q[1];
    assign sclk_s = sclk_sync_q[1];
    assign din_s  = din_sync_q[1];

    // Synchronizers and registered edge flags; din is delayed to line up with sclk_rise_q.
    // armed only sets once a settled ncs_s has been seen high, so the reset value of the
    // ncs synchronizer cannot fake a falling edge in the middle of a frame.
    always_comb begin
        ncs_sync_d  = {ncs_sync_q[0], ncs};
        sclk_sync_d = {sclk_sync_q[0], sclk};
        din_sync_d  = {din_sync_q[0], din};
        ncs_prev_d  = ncs_s;
        sclk_prev_d = sclk_s;
        ncs_rise_d  = ncs_s & ~ncs_prev_q;
        ncs_fall_d  = ~ncs_s & ncs_prev_q;
        sclk_rise_d = sclk_s & ~sclk_prev_q;
        din_d       = din_s;
        settle_d    = {settle_q[0], 1'b1};
        armed_d     = armed_q | (settle_q[1] & ncs_s);
    end

    // Front-end registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ncs_sync_q  <= 2'b11;
            sclk_sync_q <= 2'b00;
            din_sync_q  <= 2'b00;
            ncs_prev_q  <= 1'b1;
            sclk_prev_q <= 1'b0;
            ncs_rise_q  <= 1'b0;
            ncs_fall_q  <= 1'b0;
            sclk_rise_q <= 1'b0;
            din_q       <= 1'b0;
            settle_q    <= 2'b00;
            armed_q     <= 1'b0;
        end else begin
            ncs_sync_q  <= ncs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            din_sync_q  <= din_sync_d;
            ncs_prev_q  <= ncs_prev_d;
            sclk_prev_q <= sclk_prev_d;
            ncs_rise_q  <= ncs_rise_d;
            ncs_fall_q  <= ncs_fall_d;
            sclk_rise_q <= sclk_rise_d;
            din_q       <= din_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
        end
    end

    // Frame FSM: shift on sclk rises, judge the frame on the ncs rise; push/frame_err are one-cycle pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ncs_fall_q && armed_q) begin
                        state_q   <= SHIFT;
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
                    end
                end
                SHIFT: begin
                    if (ncs_rise_q) begin
                        state_q <= IDLE;
                        if (bit_cnt_q == CNTW'(SAMPLE_W)) push_q      <= 1'b1;
                        else                              frame_err_q <= 1'b1;
                    end else if (sclk_rise_q) begin
                        if (bit_cnt_q == CNTW'(SAMPLE_W)) begin
                            state_q <= ERR;
                        end else begin
                            shift_q   <= {shift_q[SAMPLE_W-2:0], din_q};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                ERR: begin
                    if (ncs_rise_q) begin
                        state_q     <= IDLE;
                        frame_err_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sample_fifo #(.W(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_q),
        .wr_data  (shift_q),
        .ready    (out_if.ready),
        .rd_data  (out_if.sample),
        .valid    (out_if.valid),
        .count    (out_if.count),
        .overflow (overflow)
    );

    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_sample_rx.sv
// Randomized bench for spi_sample_rx against a frame-level queue model.
module tb_spi_sample_rx;
    import spi_pkg::*;

    localparam int W = 11;
    localparam int D = 4;

    logic clk = 1'b0, reset = 1'b1, sclk = 1'b0, ncs = 1'b1, din = 1'b0;
    logic frame_err, overflow;
    logic ready = 1'b0, ready_fix = 1'b0, rand_rdy = 1'b0;
    logic mon_en = 1'b0, exp_ferr = 1'b0, exp_ovf = 1'b0;
    int   n_chk = 0, n_err = 0;
    logic [W-1:0] mq[$];

    spi_sample_rx_if #(.SAMPLE_W(W), .FIFO_DEPTH(D)) u_if ();
    assign u_if.ready = ready;

    spi_sample_rx #(.SAMPLE_W(W), .FIFO_DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .ncs       (ncs),
        .din       (din),
        .out_if    (u_if),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #13 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ready changes just after each rising edge, so it is stable around both sampling points
    always @(posedge clk) begin
        #1;
        ready = rand_rdy ? 1'($urandom_range(1)) : ready_fix;
    end

    // Model check every cycle; a head visible with ready high leaves at the next rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid", 32'(u_if.valid), 32'(mq.size() != 0));
            chk("count", 32'(u_if.count), 32'(mq.size()));
            if (mq.size() != 0) chk("sample", 32'(u_if.sample), 32'(mq[0]));
            chk("frame_err", 32'(frame_err), 32'(exp_ferr));
            chk("overflow", 32'(overflow), 32'(exp_ovf));
            exp_ferr = 1'b0;
            exp_ovf  = 1'b0;
            if (mq.size() != 0 && ready) void'(mq.pop_front());
        end
    end

    task automatic sclk_pulse(input logic b);
        din = b;
        #800 sclk = 1'b1;
        #800 sclk = 1'b0;
    endtask

    // One frame at 625 kHz; E0 is the edge that first captures ncs high at the pin.
    task automatic send_frame(input logic [15:0] data, input int nbits, input logic rdy_at_push);
        @(negedge clk) ncs = 1'b0;
        #800;
        for (int i = 0; i < nbits; i++) sclk_pulse(data[nbits-1-i]);
        #800;
        @(negedge clk) ncs = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        if (nbits != W) exp_ferr = 1'b1;
        if (rdy_at_push) ready_fix = 1'b1;
        @(posedge clk);
        if (nbits == W) begin
            if (mq.size() == D) exp_ovf = 1'b1;
            else                mq.push_back(data[W-1:0]);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic reset_values(input string tag);
        @(negedge clk);
        chk({tag, "_sample"}, 32'(u_if.sample), 32'd0);
        chk({tag, "_valid"}, 32'(u_if.valid), 32'd0);
        chk({tag, "_count"}, 32'(u_if.count), 32'd0);
        chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        int unsigned r;
        int len;
        #1 reset = 1'b0;
        #2 mon_en = 1'b1;
        reset_values("rst");
        repeat (3) @(posedge clk);
        #5 reset = 1'b1;
        repeat (5) @(posedge clk);

        // single good frame, consumer always ready
        ready_fix = 1'b1;
        send_frame(16'h05A3, W, 1'b0);

        // short then long frame
        send_frame(16'h0155, 10, 1'b0);
        send_frame(16'h0ABC, 12, 1'b0);

        // fill with ready low, fifth frame overflows, then drain
        ready_fix = 1'b0;
        repeat (3) @(posedge clk);
        for (int v = 1; v <= 5; v++) send_frame(16'(v), W, 1'b0);
        @(negedge clk) chk("count_full", 32'(u_if.count), 32'(D));
        ready_fix = 1'b1;
        repeat (12) @(posedge clk);

        // full buffer, ready rises exactly at the push: simultaneous push and pop
        ready_fix = 1'b0;
        repeat (3) @(posedge clk);
        for (int v = 1; v <= 4; v++) send_frame(16'(v), W, 1'b0);
        send_frame(16'h07FF, W, 1'b1);
        repeat (12) @(posedge clk);

        // reset in the middle of a frame, released while ncs still low
        @(negedge clk) ncs = 1'b0;
        #800;
        for (int i = 0; i < 6; i++) sclk_pulse(1'($urandom_range(1)));
        @(posedge clk);
        #5 reset = 1'b0;
        mq.delete();
        exp_ferr = 1'b0;
        exp_ovf  = 1'b0;
        reset_values("midrst");
        @(posedge clk);
        #5 reset = 1'b1;
        for (int i = 0; i < 5; i++) sclk_pulse(1'($urandom_range(1)));
        #800 ncs = 1'b1;
        repeat (20) @(posedge clk);
        send_frame(16'h0400, W, 1'b0);

        // sclk activity with ncs high
        for (int i = 0; i < 20; i++) sclk_pulse(1'($urandom_range(1)));
        repeat (10) @(posedge clk);

        // random frames with random back-pressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 24; k++) begin
            r   = $urandom_range(4);
            len = (r == 0) ? 10 : (r == 4) ? 12 : W;
            send_frame(16'($urandom), len, 1'b0);
        end
        rand_rdy  = 1'b0;
        ready_fix = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk) chk("count_end", 32'(u_if.count), 32'd0);
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
